benes32_seq_unscramble: RTL
===========================

Name: benes32_seq_unscramble

Overview:
- Iterative, time-multiplexed companion to the 32-lane Benes permutation switch.
- Accepts one 32-lane vector with a 9-bit routing word and applies the nine Benes stages one per clock over a single lane-register bank.
- In inverse mode it restores the original lane order of a vector that the parallel switch permuted with the same routing word. In forward mode it reproduces the parallel switch's output, which the bench uses as a golden model.
- Sits on the receive side of the permutation path, between the switch output and the downstream CNN consumer.

Parameters:
- N, 32, lane word width in bits.
- LANES, 32, lane count; fixed at 32 and not overridable.
- SEL_W, 9, routing word width; equals 2*log2(LANES)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  LANES*N  lane k occupies bits [k*N +: N].
- in_sel  in  SEL_W  routing word: bit 8 = first-stage crossbar, bit 0 = last-stage crossbar.
- in_inv  in  1  1 = inverse (unscramble), 0 = forward.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LANES*N  result vector, same packing as in_data.

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE; in_ready=1, out_valid=0, out_data=0, stage counter=0, captured sel/inv=0.
- Crossbar primitive, control bit c on pair (a,b): c=0 gives (a,b); c=1 gives (b,a).
- Stage j, j=0..8, with block size B:
  - j<4: B=32>>j. In each aligned block of B lanes, crossbar pairs (2i,2i+1) for i<B/2; first result goes to block lane i, second to lane i+B/2.
  - j=4: crossbar every pair (2i,2i+1) in place.
  - j>4: B=32>>(8-j). In each block, crossbar pairs (i, i+B/2); results go to lanes 2i and 2i+1.
- Control bit for stage j: sel[8-j] when inv=0; sel[j] when inv=1. Every crossbar in a stage shares that bit.
- Consequence: inverse output equals the forward network driven with bit-reversed sel, so forward(sel) followed by inverse(sel) is the identity.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into the bank and latch in_sel and in_inv. Go to RUN with cnt=0.
  - RUN: each edge, bank <= stage(cnt)(bank) and cnt increments. The edge that applies stage 8 moves to DONE. in_ready=0.
  - DONE: out_valid=1 and out_data=bank, held stable until out_ready. On out_valid&out_ready, go to IDLE.
- Latency: out_valid rises 9 edges after the accept edge. Minimum accept-to-accept spacing is 11 cycles with out_ready tied high.
- in_data, in_sel and in_inv are ignored outside the IDLE handshake; changing them during RUN has no effect.
- out_ready is ignored outside DONE.
- Reset in RUN or DONE drops the vector; no partial result is ever presented.
- sel=0 is the identity permutation in both modes.
- No arithmetic; lanes are moved bit-exactly and width is preserved.

Decomposition:
- Package benes_pkg:
  - Constants LANES=32, STAGES=9, SEL_W=9.
  - State enum {IDLE, RUN, DONE}.
  - Function stage_ctl(sel, j, inv) returning the stage control bit.
- One sub-module, benes32_stage: combinational single-stage permute. Inputs: bank vector, stage index (4 bits), control bit. Output: permuted vector. The top module holds the FSM, counter and bank.

Test Plan:
- Identity: lane k = k, sel=9'h000, inv=0 then inv=1 → out lane k = k in both modes; out_valid exactly 9 edges after accept.
- Single swap: lane k = k, sel=9'h100, inv=0 → out lane 2i = 2i+1 and out lane 2i+1 = 2i. Same data with sel=9'h001, inv=1 → same adjacent-pair swap.
- Round trip: 200 random vectors and random sel. Run forward with sel, feed the result back with inv=1 and the same sel → output equals the original vector. Forward-mode output also matches the parallel switch model with the same sel.
- Backpressure: out_ready held low 5 cycles in DONE → out_data stable, out_valid=1, in_ready=0. in_valid pulsed meanwhile → not accepted. After the out_ready handshake, in_ready=1 the next cycle.
- Reset mid-op: rst_n low at RUN cnt=4 → immediately out_valid=0, out_data=0. After release, in_ready=1 and a new vector with sel=9'h000 returns unchanged.
- Mode latch: in_inv and in_sel toggled during RUN → result matches the values latched at accept.

Source files
------------

// File: rtl/benes_pkg.sv
// Shared constants, FSM state type and stage-control helper for the
// sequential 32-lane Benes unscrambler.
package benes_pkg;

  localparam int LANES  = 32;
  localparam int STAGES = 9;
  localparam int SEL_W  = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Inverse mode walks the routing word in reverse so that it undoes a forward pass.
  function automatic logic stage_ctl(input logic [SEL_W-1:0] sel,
                                     input logic [3:0]       j,
                                     input logic             inv);
    logic [3:0] rj;
    rj = 4'(SEL_W - 1) - j;
    return inv ? sel[j] : sel[rj];
  endfunction

endpackage

// File: rtl/benes32_stage.sv
// Combinational single-stage Benes permute: every stage shape is built in
// parallel and the stage index selects which one drives the output.
module benes32_stage
  import benes_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [LANES*N-1:0] bank_i,
  input  logic [3:0]         stage_i,
  input  logic               ctl_i,
  output logic [LANES*N-1:0] bank_o
);

  logic [LANES*N-1:0] res [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int S = s;
    localparam int B = (S < 4) ? (LANES >> S) : ((S == 4) ? 2 : (LANES >> (8 - S)));

    logic [LANES*N-1:0] r;

    // Stages 0..4 split adjacent pairs into block halves; stages 5..8 merge halves back into pairs.
    always_comb begin
      r = '0;
      for (int blk = 0; blk < LANES; blk += B) begin
        for (int i = 0; i < B / 2; i++) begin
          if (S <= 4) begin
            r[(blk + i) * N +: N]         = ctl_i ? bank_i[(blk + 2*i + 1) * N +: N]
                                                  : bank_i[(blk + 2*i) * N +: N];
            r[(blk + i + B/2) * N +: N]   = ctl_i ? bank_i[(blk + 2*i) * N +: N]
                                                  : bank_i[(blk + 2*i + 1) * N +: N];
          end else begin
            r[(blk + 2*i) * N +: N]       = ctl_i ? bank_i[(blk + i + B/2) * N +: N]
                                                  : bank_i[(blk + i) * N +: N];
            r[(blk + 2*i + 1) * N +: N]   = ctl_i ? bank_i[(blk + i) * N +: N]
                                                  : bank_i[(blk + i + B/2) * N +: N];
          end
        end
      end
    end

    assign res[s] = r;
  end

  assign bank_o = (stage_i < 4'(STAGES)) ? res[stage_i] : bank_i;

endmodule

// File: rtl/benes32_seq_unscramble.sv
// Iterative 32-lane Benes network: one stage per clock over a single lane bank,
// forward mode matches the parallel switch, inverse mode restores lane order.
module benes32_seq_unscramble
  import benes_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*N-1:0]   in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*N-1:0]   out_data
);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [LANES*N-1:0]   bank_q, bank_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 inv_q, inv_d;
  logic [LANES*N-1:0]   stage_out;

  benes32_stage #(.N(N)) u_stage (
    .bank_i  (bank_q),
    .stage_i (cnt_q),
    .ctl_i   (stage_ctl(sel_q, cnt_q, inv_q)),
    .bank_o  (stage_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    sel_d   = sel_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bank_d  = in_data;
          sel_d   = in_sel;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bank_d = stage_out;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(STAGES - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      sel_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      sel_q   <= sel_d;
      inv_q   <= inv_d;
    end
  end

  // The bank is only exposed once all nine stages have been applied.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) ? bank_q : '0;

endmodule
